usb_pkt_tx: RTL

USB packet transmitter between the endpoint controller and the ULPI-style PHY transmit port. It accepts a byte stream from the endpoint controller using the start/stop + strobe handshake. It checks the PID, optionally appends CRC16 to data packets, and drives bytes to the PHY with a valid/ready handshake and a stop pulse. It also enforces a maximum payload length and the inter-packet gap.

---
 rtl/usb_pkt_tx.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/usb_pkt_tx.sv
// USB packet transmitter: endpoint byte stream in, PHY valid/ready bytes out, with PID check,
// payload length limit and inter-packet gap. Define USB_TX_CRC16_EN to append CRC16 to data PIDs.
module usb_pkt_tx #(
  parameter int MAX_PAYLOAD = 1024,
  parameter int IPG_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [7:0] data_in,
  input  logic       data_in_start_stop,
  output logic       data_in_strb,
  output logic       data_in_fail,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       tx_stp,
  output logic       tx_err,
  input  logic       tx_abort
);

  typedef enum logic [2:0] {
    IDLE, SEND_PID, SEND_DATA, SEND_CRC_LO, SEND_CRC_HI, STOP, GAP
  } state_e;

  localparam logic [10:0] MAX_LEN  = 11'(MAX_PAYLOAD);
  localparam logic [7:0]  GAP_LAST = 8'(IPG_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        tx_stp_q, tx_stp_d;
  logic        tx_err_q, tx_err_d;
  logic        fail_q, fail_d;
  logic [10:0] len_q, len_d;
  logic [7:0]  gap_q, gap_d;

  logic        in_payload, pid_ok, pkt_start, byte_latch, crc_append;
  logic [15:0] crc_out;

  // tx_data_q doubles as the holding register for the byte on offer to the PHY.
  assign in_payload   = (state_q == SEND_PID) || (state_q == SEND_DATA);
  assign data_in_strb = in_payload & tx_valid_q & tx_ready & ~tx_abort;
  assign pid_ok       = (data_in[7:4] == ~data_in[3:0]);
  assign pkt_start    = (state_q == IDLE) & data_in_start_stop & pid_ok;
  assign byte_latch   = data_in_strb & ~data_in_start_stop & (len_q < MAX_LEN);

`ifdef USB_TX_CRC16_EN
  logic [15:0] crc_q, crc_d;
  logic        data_pid_q, data_pid_d;

  // Reflected 0xA001 update, one input bit per step, LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c >> 1) ^ (((c[0] ^ b[i]) == 1'b1) ? 16'hA001 : 16'h0000);
    end
    return c;
  endfunction

  always_comb begin
    crc_d      = crc_q;
    data_pid_d = data_pid_q;
    if (pkt_start) begin
      crc_d      = 16'hFFFF;
      data_pid_d = (data_in[1:0] == 2'b11);  // DATA0/DATA1/DATA2/MDATA
    end else if (byte_latch) begin
      crc_d = crc16_byte(crc_q, data_in);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      crc_q      <= 16'hFFFF;
      data_pid_q <= 1'b0;
    end else begin
      crc_q      <= crc_d;
      data_pid_q <= data_pid_d;
    end
  end

  assign crc_append = data_pid_q;
  assign crc_out    = ~crc_q;
`else
  assign crc_append = 1'b0;
  assign crc_out    = 16'h0000;
`endif

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    tx_stp_d   = 1'b0;
    tx_err_d   = 1'b0;
    fail_d     = 1'b0;
    len_d      = len_q;
    gap_d      = gap_q;

    if (tx_abort && (state_q != IDLE) && (state_q != GAP)) begin
      state_d = IDLE;
      fail_d  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (pkt_start) begin
            state_d    = SEND_PID;
            tx_data_d  = data_in;
            tx_valid_d = 1'b1;
            len_d      = '0;
          end else if (data_in_start_stop) begin
            fail_d = 1'b1;
          end
        end
        SEND_PID, SEND_DATA: begin
          tx_valid_d = 1'b1;
          if (data_in_strb) begin
            if (byte_latch) begin
              state_d   = SEND_DATA;
              tx_data_d = data_in;
              len_d     = len_q + 11'd1;
            end else if (!data_in_start_stop) begin
              // one byte too many: abort the packet, the extra byte is dropped
              state_d    = STOP;
              tx_valid_d = 1'b0;
              tx_stp_d   = 1'b1;
              tx_err_d   = 1'b1;
              fail_d     = 1'b1;
            end else if (crc_append) begin
              state_d   = SEND_CRC_LO;
              tx_data_d = crc_out[7:0];
            end else begin
              state_d    = STOP;
              tx_valid_d = 1'b0;
              tx_stp_d   = 1'b1;
            end
          end
        end
        SEND_CRC_LO: begin
          tx_valid_d = 1'b1;
          if (tx_ready) begin
            state_d   = SEND_CRC_HI;
            tx_data_d = crc_out[15:8];
          end
        end
        SEND_CRC_HI: begin
          tx_valid_d = 1'b1;
          if (tx_ready) begin
            state_d    = STOP;
            tx_valid_d = 1'b0;
            tx_stp_d   = 1'b1;
          end
        end
        STOP: begin
          state_d = GAP;
          gap_d   = GAP_LAST;
        end
        GAP: begin
          if (gap_q == 8'd0) state_d = IDLE;
          else               gap_d   = gap_q - 8'd1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      tx_stp_q   <= 1'b0;
      tx_err_q   <= 1'b0;
      fail_q     <= 1'b0;
      len_q      <= '0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tx_stp_q   <= tx_stp_d;
      tx_err_q   <= tx_err_d;
      fail_q     <= fail_d;
      len_q      <= len_d;
      gap_q      <= gap_d;
    end
  end

  assign tx_data      = tx_data_q;
  assign tx_valid     = tx_valid_q;
  assign tx_stp       = tx_stp_q;
  assign tx_err       = tx_err_q;
  assign data_in_fail = fail_q;

endmodule
